// File: rtl/magnitude_stats.sv
// magnitude_stats: running statistics over the 8-bit magnitude stream.
// Tracks min/max since the last clear, the mean of each 2^WIN_LOG2-sample
// window and a saturating over-threshold count, and presents the statistic
// chosen by sel on a registered output. Pulses report threshold crossings
// and window completion one cycle after the triggering sample.
module magnitude_stats #(
    parameter int W        = 8,
    parameter int WIN_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     mag_in,
    input  logic             mag_valid,
    input  logic             clear,
    input  logic [W-1:0]     thresh,
    input  logic [1:0]       sel,
    output logic [W-1:0]     stat_out,
    output logic             over_flag,
    output logic             win_done
);

    localparam int AW = W + WIN_LOG2;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          min_q, min_d;
    logic [W-1:0]          max_q, max_d;
    logic [W-1:0]          avg_q, avg_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [WIN_LOG2-1:0]   cnt_q, cnt_d;
    logic [W-1:0]          over_cnt_q, over_cnt_d;
    logic [W-1:0]          stat_out_q, stat_out_d;
    logic                  over_flag_q, over_flag_d;
    logic                  win_done_q, win_done_d;

    // A sample only counts when clear is not asserted alongside it.
    logic                  accept_s;
    logic [AW-1:0]         acc_sum_s;

    assign accept_s  = mag_valid & ~clear;
    assign acc_sum_s = acc_q + {{WIN_LOG2{1'b0}}, mag_in};

    // State register and all statistic / output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            min_q       <= {W{1'b0}};
            max_q       <= {W{1'b0}};
            avg_q       <= {W{1'b0}};
            acc_q       <= {AW{1'b0}};
            cnt_q       <= {WIN_LOG2{1'b0}};
            over_cnt_q  <= {W{1'b0}};
            stat_out_q  <= {W{1'b0}};
            over_flag_q <= 1'b0;
            win_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            max_q       <= max_d;
            avg_q       <= avg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            over_cnt_q  <= over_cnt_d;
            stat_out_q  <= stat_out_d;
            over_flag_q <= over_flag_d;
            win_done_q  <= win_done_d;
        end
    end

    // Next-state: first accepted sample leaves EMPTY, clear returns to it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) state_d = ST_RUN;
                else          state_d = ST_EMPTY;
            end
            ST_RUN: begin
                if (clear) state_d = ST_EMPTY;
                else       state_d = ST_RUN;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Statistic updates and pulse generation for the current cycle.
    always_comb begin
        min_d       = min_q;
        max_d       = max_q;
        avg_d       = avg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        over_cnt_d  = over_cnt_q;
        over_flag_d = 1'b0;
        win_done_d  = 1'b0;
        if (clear) begin
            min_d      = {W{1'b0}};
            max_d      = {W{1'b0}};
            avg_d      = {W{1'b0}};
            acc_d      = {AW{1'b0}};
            cnt_d      = {WIN_LOG2{1'b0}};
            over_cnt_d = {W{1'b0}};
        end else if (mag_valid) begin
            // EMPTY seeds min/max directly; otherwise compare.
            if (state_q == ST_EMPTY) begin
                min_d = mag_in;
                max_d = mag_in;
            end else begin
                if (mag_in < min_q) min_d = mag_in;
                else                min_d = min_q;
                if (mag_in > max_q) max_d = mag_in;
                else                max_d = max_q;
            end
            // Last sample of a window closes it; acc is wide enough not to wrap.
            if (cnt_q == {WIN_LOG2{1'b1}}) begin
                avg_d      = acc_sum_s[AW-1:WIN_LOG2];
                acc_d      = {AW{1'b0}};
                cnt_d      = {WIN_LOG2{1'b0}};
                win_done_d = 1'b1;
            end else begin
                acc_d = acc_sum_s;
                cnt_d = cnt_q + WIN_LOG2'(1);
            end
            // Strictly greater than thresh counts as over.
            if (mag_in > thresh) begin
                over_flag_d = 1'b1;
                if (over_cnt_q != {W{1'b1}}) over_cnt_d = over_cnt_q + W'(1);
                else                         over_cnt_d = over_cnt_q;
            end else begin
                over_flag_d = 1'b0;
            end
        end else begin
            over_flag_d = 1'b0;
        end
    end

    // Output mux samples the registered statistics, adding one cycle of latency.
    always_comb begin
        stat_out_d = {W{1'b0}};
        case (sel)
            2'b00:   stat_out_d = min_q;
            2'b01:   stat_out_d = max_q;
            2'b10:   stat_out_d = avg_q;
            2'b11:   stat_out_d = over_cnt_q;
            default: stat_out_d = {W{1'b0}};
        endcase
    end

    assign stat_out  = stat_out_q;
    assign over_flag = over_flag_q;
    assign win_done  = win_done_q;

endmodule
